// File: rtl/alu_arbiter.sv
// Purpose: lets two requesters share one combinational ALU, with a one-entry response register per requester.
// Latency: a request accepted at clock edge N has its result registered and visible in cycle N+1; up to one op per cycle in total.
// Backpressure: a port is granted only when its response slot is empty or is being drained that cycle; a full, stalled slot holds its data.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_0,
  input  logic             req_valid_1,
  output logic             req_ready_0,
  output logic             req_ready_1,
  input  logic [OPW-1:0]   req_opcode_0,
  input  logic [OPW-1:0]   req_opcode_1,
  input  logic [WIDTH-1:0] req_left_0,
  input  logic [WIDTH-1:0] req_left_1,
  input  logic [WIDTH-1:0] req_right_0,
  input  logic [WIDTH-1:0] req_right_1,
  output logic             resp_valid_0,
  output logic             resp_valid_1,
  input  logic             resp_ready_0,
  input  logic             resp_ready_1,
  output logic [WIDTH-1:0] resp_data_0,
  output logic [WIDTH-1:0] resp_data_1,
  output logic [OPW-1:0]   alu_opcode,
  output logic [WIDTH-1:0] alu_left,
  output logic [WIDTH-1:0] alu_right,
  input  logic [WIDTH-1:0] alu_result
);

  // Port that won the most recent grant; resets to 1 so port 0 wins the first conflict.
  logic last_grant;

  logic avail_0, avail_1;
  logic elig_0, elig_1;
  logic grant_0, grant_1;

  // Round-robin arbitration between ports whose slot can accept a result this cycle.
  always_comb begin
    avail_0 = 1'b0;
    avail_1 = 1'b0;
    elig_0  = 1'b0;
    elig_1  = 1'b0;
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    // A full slot being drained this cycle counts as free, so a port can keep issuing every cycle.
    avail_0 = !resp_valid_0 || resp_ready_0;
    avail_1 = !resp_valid_1 || resp_ready_1;
    elig_0  = req_valid_0 && avail_0;
    elig_1  = req_valid_1 && avail_1;
    // Grants are held off while reset is asserted so no request is accepted during reset.
    grant_0 = rst_n && elig_0 && (!elig_1 || last_grant);
    grant_1 = rst_n && elig_1 && (!elig_0 || !last_grant);
  end

  assign req_ready_0 = grant_0;
  assign req_ready_1 = grant_1;

  // Route the winner's operands to the ALU; with no grant, port 0's inputs pass through unused.
  always_comb begin
    alu_opcode = req_opcode_0;
    alu_left   = req_left_0;
    alu_right  = req_right_0;
    if (grant_1) begin
      alu_opcode = req_opcode_1;
      alu_left   = req_left_1;
      alu_right  = req_right_1;
    end
  end

  // Round-robin pointer moves only when something is granted; idle cycles keep it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (grant_0) begin
      last_grant <= 1'b0;
    end else if (grant_1) begin
      last_grant <= 1'b1;
    end
  end

  // Response slot 0: capture on grant (also when draining the same cycle), otherwise clear on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_0 <= 1'b0;
      resp_data_0  <= '0;
    end else if (grant_0) begin
      resp_valid_0 <= 1'b1;
      resp_data_0  <= alu_result;
    end else if (resp_ready_0) begin
      resp_valid_0 <= 1'b0;
    end
  end

  // Response slot 1: capture on grant (also when draining the same cycle), otherwise clear on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_1 <= 1'b0;
      resp_data_1  <= '0;
    end else if (grant_1) begin
      resp_valid_1 <= 1'b1;
      resp_data_1  <= alu_result;
    end else if (resp_ready_1) begin
      resp_valid_1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose: directed checks of the two-port ALU arbiter against hand-computed values.
// Latency: results are expected one cycle after the accepting edge.
// Backpressure: covers stalled slots, same-cycle pass-through and asynchronous reset.
module tb_alu_arbiter;
  localparam int WIDTH = 32;
  localparam int OPW   = 3;
  localparam logic [OPW-1:0] ALU_OP_ADD = 3'd0;
  localparam logic [OPW-1:0] ALU_OP_SUB = 3'd1;
  localparam logic [OPW-1:0] ALU_OP_AND = 3'd2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid_0 = 1'b0, req_valid_1 = 1'b0;
  logic             req_ready_0, req_ready_1;
  logic [OPW-1:0]   req_opcode_0 = '0, req_opcode_1 = '0;
  logic [WIDTH-1:0] req_left_0 = '0, req_left_1 = '0;
  logic [WIDTH-1:0] req_right_0 = '0, req_right_1 = '0;
  logic             resp_valid_0, resp_valid_1;
  logic             resp_ready_0 = 1'b0, resp_ready_1 = 1'b0;
  logic [WIDTH-1:0] resp_data_0, resp_data_1;
  logic [OPW-1:0]   alu_opcode;
  logic [WIDTH-1:0] alu_left, alu_right, alu_result;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_opcode_0(req_opcode_0), .req_opcode_1(req_opcode_1),
    .req_left_0(req_left_0), .req_left_1(req_left_1),
    .req_right_0(req_right_0), .req_right_1(req_right_1),
    .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
    .resp_ready_0(resp_ready_0), .resp_ready_1(resp_ready_1),
    .resp_data_0(resp_data_0), .resp_data_1(resp_data_1),
    .alu_opcode(alu_opcode), .alu_left(alu_left), .alu_right(alu_right),
    .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  // Combinational ALU model standing in for the shared ALU instance.
  always_comb begin
    alu_result = '0;
    case (alu_opcode)
      ALU_OP_ADD: alu_result = alu_left + alu_right;
      ALU_OP_SUB: alu_result = alu_left - alu_right;
      ALU_OP_AND: alu_result = alu_left & alu_right;
      default:    alu_result = '0;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    resp_ready_0 = 1'b0; resp_ready_1 = 1'b0;
    req_opcode_0 = '0; req_opcode_1 = '0;
    req_left_0 = '0; req_left_1 = '0;
    req_right_0 = '0; req_right_1 = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    step();
    n_checks++; if (req_ready_0 !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready_0 got %b want 0", req_ready_0); end
    n_checks++; if (req_ready_1 !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready_1 got %b want 0", req_ready_1); end
    n_checks++; if (resp_valid_0 !== 1'b0 || resp_valid_1 !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b%b want 00", resp_valid_0, resp_valid_1); end
    n_checks++; if (resp_data_0 !== 32'd0 || resp_data_1 !== 32'd0) begin n_fail++; $display("FAIL reset_resp_data got %0d/%0d want 0/0", resp_data_0, resp_data_1); end
    idle_inputs();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    apply_reset();
    req_valid_0 = 1'b1; req_opcode_0 = ALU_OP_ADD; req_left_0 = 32'd4; req_right_0 = 32'd3;
    resp_ready_0 = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin n_fail++; $display("FAIL single_ready got %b%b want 10", req_ready_0, req_ready_1); end
    n_checks++; if (alu_left !== 32'd4 || alu_right !== 32'd3) begin n_fail++; $display("FAIL single_alu_ops got %0d,%0d want 4,3", alu_left, alu_right); end
    step();
    req_valid_0 = 1'b0;
    n_checks++; if (resp_valid_0 !== 1'b1 || resp_data_0 !== 32'd7) begin n_fail++; $display("FAIL single_resp0 got v=%b d=%0d want v=1 d=7", resp_valid_0, resp_data_0); end
    n_checks++; if (resp_valid_1 !== 1'b0 || resp_data_1 !== 32'd0) begin n_fail++; $display("FAIL single_resp1 got v=%b d=%0d want v=0 d=0", resp_valid_1, resp_data_1); end
    step();
    n_checks++; if (resp_valid_0 !== 1'b0 || resp_data_0 !== 32'd7) begin n_fail++; $display("FAIL single_drain got v=%b d=%0d want v=0 d=7", resp_valid_0, resp_data_0); end
  endtask

  task automatic test_round_robin();
    logic exp0;
    apply_reset();
    req_valid_0 = 1'b1; req_opcode_0 = ALU_OP_AND; req_left_0 = 32'd12; req_right_0 = 32'd10;
    req_valid_1 = 1'b1; req_opcode_1 = ALU_OP_SUB; req_left_1 = 32'd7;  req_right_1 = 32'd3;
    resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp0 = (i % 2 == 0);
      @(negedge clk);
      n_checks++; if (req_ready_0 !== exp0 || req_ready_1 !== !exp0) begin n_fail++; $display("FAIL rr_grant[%0d] got %b%b want %b%b", i, req_ready_0, req_ready_1, exp0, !exp0); end
      step();
      if (exp0) begin
        n_checks++; if (resp_valid_0 !== 1'b1 || resp_data_0 !== 32'd8 || resp_valid_1 !== 1'b0) begin n_fail++; $display("FAIL rr_resp[%0d] got v0=%b d0=%0d v1=%b want 1,8,0", i, resp_valid_0, resp_data_0, resp_valid_1); end
      end else begin
        n_checks++; if (resp_valid_1 !== 1'b1 || resp_data_1 !== 32'd4 || resp_valid_0 !== 1'b0) begin n_fail++; $display("FAIL rr_resp[%0d] got v1=%b d1=%0d v0=%b want 1,4,0", i, resp_valid_1, resp_data_1, resp_valid_0); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    apply_reset();
    req_valid_1 = 1'b1; req_opcode_1 = ALU_OP_SUB; req_left_1 = 32'd7; req_right_1 = 32'd3;
    step();
    n_checks++; if (resp_valid_1 !== 1'b1 || resp_data_1 !== 32'd4) begin n_fail++; $display("FAIL bp_fill got v=%b d=%0d want v=1 d=4", resp_valid_1, resp_data_1); end
    req_left_1 = 32'd20; req_right_1 = 32'd5;
    req_valid_0 = 1'b1; req_opcode_0 = ALU_OP_ADD; req_left_0 = 32'd4; req_right_0 = 32'd3;
    resp_ready_0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin n_fail++; $display("FAIL bp_grant[%0d] got %b%b want 10", i, req_ready_0, req_ready_1); end
      step();
      n_checks++; if (resp_valid_1 !== 1'b1 || resp_data_1 !== 32'd4 || resp_data_0 !== 32'd7) begin n_fail++; $display("FAIL bp_hold[%0d] got v1=%b d1=%0d d0=%0d want 1,4,7", i, resp_valid_1, resp_data_1, resp_data_0); end
    end
    resp_ready_1 = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready_0 !== 1'b0 || req_ready_1 !== 1'b1) begin n_fail++; $display("FAIL bp_pass_grant got %b%b want 01", req_ready_0, req_ready_1); end
    step();
    n_checks++; if (resp_valid_1 !== 1'b1 || resp_data_1 !== 32'd15) begin n_fail++; $display("FAIL bp_pass_data got v=%b d=%0d want v=1 d=15", resp_valid_1, resp_data_1); end
    n_checks++; if (resp_valid_0 !== 1'b0) begin n_fail++; $display("FAIL bp_drain0 got %b want 0", resp_valid_0); end
    idle_inputs();
  endtask

  task automatic test_idle_pointer();
    apply_reset();
    resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
    req_valid_1 = 1'b1; req_opcode_1 = ALU_OP_ADD; req_left_1 = 32'd1; req_right_1 = 32'd1;
    @(negedge clk);
    n_checks++; if (req_ready_1 !== 1'b1) begin n_fail++; $display("FAIL idle_first_grant got %b want 1", req_ready_1); end
    step();
    req_valid_1 = 1'b0;
    step(); step(); step();
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin n_fail++; $display("FAIL idle_pointer got %b%b want 10", req_ready_0, req_ready_1); end
    step();
    idle_inputs();
  endtask

  task automatic test_async_reset();
    apply_reset();
    req_valid_0 = 1'b1; req_opcode_0 = ALU_OP_ADD; req_left_0 = 32'd2; req_right_0 = 32'd2;
    req_valid_1 = 1'b1; req_opcode_1 = ALU_OP_ADD; req_left_1 = 32'd5; req_right_1 = 32'd5;
    step();
    step();
    n_checks++; if (resp_valid_0 !== 1'b1 || resp_valid_1 !== 1'b1 || resp_data_0 !== 32'd4 || resp_data_1 !== 32'd10) begin n_fail++; $display("FAIL ar_fill got v=%b%b d=%0d/%0d want 11 4/10", resp_valid_0, resp_valid_1, resp_data_0, resp_data_1); end
    resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
    #1;
    n_checks++; if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin n_fail++; $display("FAIL ar_pre_ready got %b%b want 10", req_ready_0, req_ready_1); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (resp_valid_0 !== 1'b0 || resp_valid_1 !== 1'b0) begin n_fail++; $display("FAIL ar_valid_drop got %b%b want 00", resp_valid_0, resp_valid_1); end
    n_checks++; if (req_ready_0 !== 1'b0 || req_ready_1 !== 1'b0) begin n_fail++; $display("FAIL ar_ready_drop got %b%b want 00", req_ready_0, req_ready_1); end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin n_fail++; $display("FAIL ar_post_grant got %b%b want 10", req_ready_0, req_ready_1); end
    step();
    n_checks++; if (resp_valid_0 !== 1'b1 || resp_data_0 !== 32'd4) begin n_fail++; $display("FAIL ar_post_resp got v=%b d=%0d want v=1 d=4", resp_valid_0, resp_data_0); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_idle_pointer();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters: port 0 is the execute stage, port 1 is the address/branch-target unit.
- Each requester uses a valid/ready request handshake and has its own one-entry response holding register with valid/ready.
- At most one operation is issued to the ALU per cycle. Its result is captured into the winning requester's response slot.
- Sits between the pipeline stages and the ALU instance; drives the ALU opcode/left/right inputs and reads its result.

Parameters:
- WIDTH, 32, operand/result width in bits.
- OPW, 3, ALU opcode width. Values come from the shared parameters header (ALU_OP_ADD, ALU_OP_AND, ALU_OP_SUB, ...).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid_0 / req_valid_1  input  1  requester i has an operation.
- req_ready_0 / req_ready_1  output  1  request i accepted this cycle when valid and ready are both high.
- req_opcode_0 / req_opcode_1  input  OPW  opcode for requester i.
- req_left_0 / req_left_1  input  WIDTH  left operand for requester i.
- req_right_0 / req_right_1  input  WIDTH  right operand for requester i.
- resp_valid_0 / resp_valid_1  output  1  response slot i holds a result.
- resp_ready_0 / resp_ready_1  input  1  consumer i takes the result.
- resp_data_0 / resp_data_1  output  WIDTH  registered result for requester i.
- alu_opcode  output  OPW  to ALU opcode.
- alu_left  output  WIDTH  to ALU left.
- alu_right  output  WIDTH  to ALU right.
- alu_result  input  WIDTH  from ALU result (combinational, same cycle).

Behaviour:
- Reset (async, rst_n low):
  - resp_valid_0/1 = 0, resp_data_0/1 = 0.
  - Round-robin pointer last_grant = 1, so port 0 wins the first conflict.
  - req_ready_0/1 = 0 while rst_n is low.
- Slot availability:
  - avail_i = !resp_valid_i || resp_ready_i.
  - A full slot that is being drained in the same cycle counts as free (pass-through, no bubble).
- Eligibility: elig_i = req_valid_i && avail_i.
- Arbitration (combinational, per cycle):
  - Only elig_0 → grant 0.
  - Only elig_1 → grant 1.
  - Both eligible → grant the port != last_grant.
  - Neither eligible → no grant.
- Handshake: req_ready_i = grant_i. At most one req_ready is high per cycle. req_ready never asserts for a port whose slot cannot accept.
- ALU drive:
  - alu_opcode/left/right = operands of the granted port.
  - With no grant, they are port 0's inputs (don't-care; must not affect state).
- Capture, on the clock edge with grant_i:
  - resp_data_i <= alu_result, resp_valid_i <= 1, last_grant <= i.
- Drain: resp_valid_i && resp_ready_i with no new grant to i → resp_valid_i <= 0. resp_data_i holds its last value.
- Simultaneous drain and grant on the same port → resp_valid_i stays 1 and resp_data_i takes the new result.
- Stability: resp_valid_i and resp_data_i stay stable while resp_valid_i && !resp_ready_i.
- Latency and throughput:
  - Request accepted at edge N → result visible on resp_data_i after edge N, i.e. valid in cycle N+1.
  - Aggregate throughput is 1 op/cycle.
  - Each port sustains 1 op/cycle when its consumer holds resp_ready high.
- last_grant updates only on a grant; idle cycles preserve it.
- Arithmetic: none internal. Results are the ALU's WIDTH-bit output unchanged, wrap-around as produced by the ALU.
- Reset mid-operation: pending results are discarded, valids cleared immediately (asynchronously), pointer returns to 1.

Test Plan:
- Single request: port 0 ALU_OP_ADD, 4, 3, resp_ready_0=1 → req_ready_0=1 that cycle; next cycle resp_valid_0=1, resp_data_0=7; port 1 signals untouched.
- Conflict round-robin: both ports valid for 4 cycles. Port 0 sends ALU_OP_AND 0b1100, 0b1010; port 1 sends ALU_OP_SUB 7, 3; both resp_ready=1.
  - Grants alternate 0, 1, 0, 1 starting with 0.
  - resp_data_0 = 8, resp_data_1 = 4.
- Backpressure: port 1 result 4 pending with resp_ready_1=0; port 1 keeps requesting while port 0 also requests.
  - req_ready_1 stays 0; port 0 receives every grant.
  - resp_data_1 stays 4 until resp_ready_1 rises.
  - On that cycle port 1 is granted (pass-through), and the new result replaces 4 without resp_valid_1 dropping.
- Idle pointer hold: grant port 1, then 3 idle cycles, then both request → port 0 granted first.
- Async reset: assert rst_n=0 mid-cycle while both slots valid → resp_valid_0/1 and req_ready_0/1 fall immediately without a clock edge. After release, a conflict grants port 0 first.
